// File: rtl/bca_pkg.sv
// Shared types for the parametrised bit-counting (BCA) block.
package bca_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } bca_state_t;

endpackage

// File: rtl/bca_chunk_popcount.sv
// Combinational popcount of one STEP-bit chunk of the operand.
module bca_chunk_popcount #(
    parameter int STEP = 1,
    parameter int PW   = $clog2(STEP + 1)
) (
    input  logic [STEP-1:0] bits,
    output logic [PW-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < STEP; i++) begin
            count = count + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/bca_param_counter.sv
// Counts set (or clear) bits of a WIDTH-bit operand, STEP bits per cycle,
// stopping as soon as the remaining shifted operand is zero.
module bca_param_counter
    import bca_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             count_zeros,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    result
);

    localparam int            PW      = $clog2(STEP + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    generate
        if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("bca_param_counter: need WIDTH >= 2 and STEP >= 1 dividing WIDTH");
        end
    endgenerate

    bca_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [PW-1:0]    chunk_ones;
    logic [WIDTH-1:0] data_shr;

    bca_chunk_popcount #(
        .STEP (STEP)
    ) u_chunk_popcount (
        .bits  (data_q[STEP-1:0]),
        .count (chunk_ones)
    );

    // With STEP == WIDTH the whole operand is consumed in one add cycle.
    generate
        if (STEP == WIDTH) begin : g_shr_all
            assign data_shr = '0;
        end else begin : g_shr_step
            assign data_shr = data_q >> STEP;
        end
    endgenerate

    // Handshake: start is a level. It is accepted on any edge where it is
    // sampled high in IDLE; the result is valid while done is high, and start
    // must be sampled low in DONE before another operation can be accepted.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                data_d = data_in;
                mode_d = count_zeros;
                if (start) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
                end
            end
            S_COUNT: begin
                if (data_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d  = cnt_q + CW'(chunk_ones);
                    data_d = data_shr;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign busy   = (state_q == S_COUNT);
    assign done   = (state_q == S_DONE);
    // Zeros are counted as WIDTH minus ones, so early termination holds in both modes.
    assign result = mode_q ? (WIDTH_C - cnt_q) : cnt_q;

endmodule

// File: tb/tb_bca_param_counter.sv
// Bench for bca_param_counter: three parameterisations checked against a
// popcount/latency reference model, directed cases then random operands.
module tb_bca_param_counter;

    logic        clk;
    logic        reset_n;
    logic        a_start, a_mode;
    logic [7:0]  a_data;
    logic        b_start, b_mode;
    logic [15:0] b_data;
    logic        a_busy, a_done, c_busy, c_done, b_busy, b_done;
    logic [3:0]  a_res, c_res;
    logic [4:0]  b_res;

    int n_total = 0;
    int n_bad   = 0;

    // a: WIDTH=8 STEP=1; c: WIDTH=8 STEP=8 (shares a's inputs); b: WIDTH=16 STEP=4
    bca_param_counter #(.WIDTH(8), .STEP(1)) u_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .count_zeros(a_mode),
        .data_in(a_data), .busy(a_busy), .done(a_done), .result(a_res)
    );

    bca_param_counter #(.WIDTH(8), .STEP(8)) u_c (
        .clk(clk), .reset_n(reset_n), .start(a_start), .count_zeros(a_mode),
        .data_in(a_data), .busy(c_busy), .done(c_done), .result(c_res)
    );

    bca_param_counter #(.WIDTH(16), .STEP(4)) u_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .count_zeros(b_mode),
        .data_in(b_data), .busy(b_busy), .done(b_done), .result(b_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ones_of(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int exp_result(input logic [31:0] v, input logic mode, input int width);
        return mode ? width - ones_of(v) : ones_of(v);
    endfunction

    function automatic int exp_latency(input logic [31:0] v, input int step);
        int m = -1;
        for (int i = 0; i < 32; i++) if (v[i]) m = i;
        if (m < 0) return 1;
        return (m + step) / step + 1;
    endfunction

    // Starts at the accepting edge; inputs already driven and start high.
    task automatic observe();
        int ea_res, ec_res, eb_res, ea_lat, ec_lat, eb_lat;
        int la, lc, lb;
        ea_res = exp_result({24'b0, a_data}, a_mode, 8);
        ec_res = ea_res;
        eb_res = exp_result({16'b0, b_data}, b_mode, 16);
        ea_lat = exp_latency({24'b0, a_data}, 1);
        ec_lat = exp_latency({24'b0, a_data}, 8);
        eb_lat = exp_latency({16'b0, b_data}, 4);
        la = 0; lc = 0; lb = 0;
        @(posedge clk); #1;
        check("busy_a_after_accept", a_busy, 1);
        check("busy_b_after_accept", b_busy, 1);
        for (int e = 1; e <= 40 && (la == 0 || lc == 0 || lb == 0); e++) begin
            @(posedge clk); #1;
            if (a_done && la == 0) la = e;
            if (c_done && lc == 0) lc = e;
            if (b_done && lb == 0) lb = e;
        end
        check("latency_a", la, ea_lat);
        check("latency_c", lc, ec_lat);
        check("latency_b", lb, eb_lat);
        check("result_a", a_res, ea_res);
        check("result_c", c_res, ec_res);
        check("result_b", b_res, eb_res);
        check("busy_a_in_done", a_busy, 0);
        // Inputs change while DONE is held: result must not move.
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            a_data = ~a_data;
            a_mode = ~a_mode;
            b_data = ~b_data;
            b_mode = ~b_mode;
            @(posedge clk); #1;
            check("hold_done_a", a_done, 1);
            check("hold_done_b", b_done, 1);
            check("hold_result_a", a_res, ea_res);
            check("hold_result_c", c_res, ec_res);
            check("hold_result_b", b_res, eb_res);
        end
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        @(posedge clk); #1;
        check("idle_done_a", a_done, 0);
        check("idle_done_c", c_done, 0);
        check("idle_done_b", b_done, 0);
        check("idle_busy_a", a_busy, 0);
    endtask

    task automatic run(input logic [7:0] d8, input logic m8,
                       input logic [15:0] d16, input logic m16);
        @(negedge clk);
        a_data  = d8;
        a_mode  = m8;
        a_start = 1'b1;
        b_data  = d16;
        b_mode  = m16;
        b_start = 1'b1;
        observe();
    endtask

    initial begin
        reset_n = 1'b0;
        a_start = 1'b0; a_mode = 1'b0; a_data = 8'h5A;
        b_start = 1'b0; b_mode = 1'b0; b_data = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy_a", a_busy, 0);
        check("reset_done_a", a_done, 0);
        check("reset_result_a", a_res, 0);
        check("reset_result_b", b_res, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run(8'b01000100, 1'b0, 16'hF00F, 1'b0);
        run(8'b01000100, 1'b1, 16'hF00F, 1'b1);
        run(8'h00, 1'b0, 16'h0000, 1'b0);
        run(8'h00, 1'b1, 16'h0000, 1'b1);
        run(8'hFF, 1'b0, 16'hFFFF, 1'b1);
        run(8'h80, 1'b1, 16'h0001, 1'b0);

        // Reset mid-COUNT aborts without a clock edge.
        @(negedge clk);
        a_data = 8'hFF; a_mode = 1'b1; a_start = 1'b1;
        b_data = 16'hFFFF; b_mode = 1'b1; b_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_busy_a", a_busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy_a", a_busy, 0);
        check("abort_done_a", a_done, 0);
        check("abort_result_a", a_res, 0);
        check("abort_busy_b", b_busy, 0);
        check("abort_result_b", b_res, 0);
        check("abort_result_c", c_res, 0);
        a_data = 8'h44; a_mode = 1'b0;
        b_data = 16'h0F00; b_mode = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        observe();

        run(8'h03, 1'b0, 16'h8000, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0]  d8;
            logic [15:0] d16;
            d8  = 8'($urandom);
            d16 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d8 = d8 >> $urandom_range(0, 8);
            if ($urandom_range(0, 3) == 0) d16 = d16 >> $urandom_range(0, 16);
            run(d8, 1'($urandom_range(0, 1)), d16, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
